// File: rtl/io_timer_gpio.sv
`timescale 1ns/100ps
// io_timer_gpio: memory-mapped LED register, synchronised switch input and a
// 32-bit down-counting timer with expiry flag and level interrupt.
module io_timer_gpio #(
  parameter int LED_W = 16,
  parameter int SW_W  = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ioCe,
  input  logic             ioWe,
  input  logic [31:0]      ioAddr,
  input  logic [31:0]      ioWtData,
  output logic [31:0]      ioRdData,
  input  logic [SW_W-1:0]  sw_in,
  output logic [LED_W-1:0] led_out,
  output logic             irq
);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_RUN  = 1'b1;

  localparam logic [7:0] OFF_LED    = 8'h00;
  localparam logic [7:0] OFF_SW     = 8'h04;
  localparam logic [7:0] OFF_CTRL   = 8'h08;
  localparam logic [7:0] OFF_LOAD   = 8'h0C;
  localparam logic [7:0] OFF_COUNT  = 8'h10;
  localparam logic [7:0] OFF_STATUS = 8'h14;

  logic             sel_s;
  logic [7:0]       off_s;
  logic             wr_led_s, wr_ctrl_s, wr_load_s, wr_status_s;

  logic [LED_W-1:0] led_q, led_d;
  logic [SW_W-1:0]  sw_meta_q, sw_meta_d, sw_sync_q, sw_sync_d;
  logic             en_q, en_d, auto_q, auto_d, ie_q, ie_d;
  logic [31:0]      load_q, load_d, count_q, count_d;
  logic             exp_q, exp_d;
  logic [0:0]       state_q, state_d;
  logic [31:0]      rd_s;
  logic             unused_s;

  // Address decode and write strobes
  always_comb begin
    off_s       = ioAddr[7:0];
    sel_s       = ioCe && (ioAddr[27:8] == 20'd0) && (ioAddr[1:0] == 2'd0);
    wr_led_s    = sel_s && ioWe && (off_s == OFF_LED);
    wr_ctrl_s   = sel_s && ioWe && (off_s == OFF_CTRL);
    wr_load_s   = sel_s && ioWe && (off_s == OFF_LOAD);
    wr_status_s = sel_s && ioWe && (off_s == OFF_STATUS);
  end

  // Register and timer next-state logic
  always_comb begin
    led_d     = led_q;
    sw_meta_d = sw_in;
    sw_sync_d = sw_meta_q;
    en_d      = en_q;
    auto_d    = auto_q;
    ie_d      = ie_q;
    load_d    = load_q;
    count_d   = count_q;
    exp_d     = exp_q;
    state_d   = state_q;

    if (wr_led_s) begin
      led_d = ioWtData[LED_W-1:0];
    end else begin
      led_d = led_q;
    end

    if (wr_load_s) begin
      load_d = ioWtData;
    end else begin
      load_d = load_q;
    end

    // Clear first so a same-edge expiry below wins
    if (wr_status_s && ioWtData[0]) begin
      exp_d = 1'b0;
    end else begin
      exp_d = exp_q;
    end

    if (wr_ctrl_s) begin
      en_d   = ioWtData[0];
      auto_d = ioWtData[1];
      ie_d   = ioWtData[2];
      if (ioWtData[0]) begin
        count_d = load_q;
        state_d = ST_RUN;
      end else begin
        state_d = ST_IDLE;
      end
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_IDLE;
        ST_RUN: begin
          if (count_q != 32'd0) begin
            count_d = count_q - 32'd1;
          end else begin
            exp_d = 1'b1;
            if (auto_q) begin
              count_d = load_q;
            end else begin
              en_d    = 1'b0;
              state_d = ST_IDLE;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Combinational read mux
  always_comb begin
    rd_s = 32'd0;
    if (sel_s) begin
      case (off_s)
        OFF_LED:    rd_s[LED_W-1:0] = led_q;
        OFF_SW:     rd_s[SW_W-1:0]  = sw_sync_q;
        OFF_CTRL:   rd_s[2:0]       = {ie_q, auto_q, en_q};
        OFF_LOAD:   rd_s            = load_q;
        OFF_COUNT:  rd_s            = count_q;
        OFF_STATUS: rd_s[0]         = exp_q;
        default:    rd_s            = 32'd0;
      endcase
    end else begin
      rd_s = 32'd0;
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q     <= '0;
      sw_meta_q <= '0;
      sw_sync_q <= '0;
      en_q      <= 1'b0;
      auto_q    <= 1'b0;
      ie_q      <= 1'b0;
      load_q    <= 32'd0;
      count_q   <= 32'd0;
      exp_q     <= 1'b0;
      state_q   <= ST_IDLE;
    end else begin
      led_q     <= led_d;
      sw_meta_q <= sw_meta_d;
      sw_sync_q <= sw_sync_d;
      en_q      <= en_d;
      auto_q    <= auto_d;
      ie_q      <= ie_d;
      load_q    <= load_d;
      count_q   <= count_d;
      exp_q     <= exp_d;
      state_q   <= state_d;
    end
  end

  assign ioRdData = rd_s;
  assign led_out  = led_q;
  assign irq      = exp_q & ie_q;
  assign unused_s = ^{ioAddr[31:28], ioWtData};

endmodule

// File: tb/tb_io_timer_gpio.sv
`timescale 1ns/100ps
// Self-checking bench for io_timer_gpio: expected read values are queued
// when stimulus is applied and compared as the bus read returns.
module tb_io_timer_gpio;
  localparam logic [31:0] A_LED   = 32'h7000_0000;
  localparam logic [31:0] A_SW    = 32'h7000_0004;
  localparam logic [31:0] A_CTRL  = 32'h7000_0008;
  localparam logic [31:0] A_LOAD  = 32'h7000_000C;
  localparam logic [31:0] A_COUNT = 32'h7000_0010;
  localparam logic [31:0] A_STAT  = 32'h7000_0014;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        ioCe = 1'b0;
  logic        ioWe = 1'b0;
  logic [31:0] ioAddr = 32'd0;
  logic [31:0] ioWtData = 32'd0;
  logic [31:0] ioRdData;
  logic [15:0] sw_in = 16'd0;
  logic [15:0] led_out;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] sb[$];
  logic [31:0] got;
  logic [31:0] exp_v;

  io_timer_gpio #(.LED_W(16), .SW_W(16)) dut (
    .clk(clk), .rst(rst), .ioCe(ioCe), .ioWe(ioWe), .ioAddr(ioAddr),
    .ioWtData(ioWtData), .ioRdData(ioRdData), .sw_in(sw_in),
    .led_out(led_out), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    ioCe = 1'b1; ioWe = 1'b1; ioAddr = a; ioWtData = d;
    @(posedge clk);
    #1;
    ioCe = 1'b0; ioWe = 1'b0; ioAddr = 32'd0; ioWtData = 32'd0;
  endtask

  task automatic rd(input logic [31:0] a, input logic ce, output logic [31:0] d);
    ioCe = ce; ioWe = 1'b0; ioAddr = a;
    #0.2;
    d = ioRdData;
    ioCe = 1'b0; ioAddr = 32'd0;
  endtask

  task automatic test_reset();
    logic [31:0] tbl[4];
    logic [31:0] regs[6];
    tbl  = '{A_LED, A_CTRL, A_LOAD, A_STAT};
    regs = '{A_LED, A_SW, A_CTRL, A_LOAD, A_COUNT, A_STAT};
    rst = 1'b1;
    repeat (2) wr(tbl[$urandom_range(0, 3)], $urandom | 32'h0000_0007);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 6; i++) sb.push_back(32'd0);
    for (int i = 0; i < 6; i++) begin
      rd(regs[i], 1'b1, got);
      exp_v = sb.pop_front();
      checks++;
      if (got !== exp_v) begin errors++; $display("FAIL reset_reg%0d got %h expected %h", i, got, exp_v); end
    end
    checks++;
    if (led_out !== 16'd0) begin errors++; $display("FAIL reset_led_out got %h expected 0", led_out); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq got %b expected 0", irq); end
  endtask

  task automatic test_led_sw();
    wr(A_LED, 32'h0000_A5A5);
    checks++;
    if (led_out !== 16'hA5A5) begin errors++; $display("FAIL led_out got %h expected a5a5", led_out); end
    sb.push_back(32'h0000_A5A5);
    rd(A_LED, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL led_read got %h expected %h", got, exp_v); end
    wr(A_LED, 32'hFFFF_FFFF);
    sb.push_back(32'h0000_FFFF);
    rd(A_LED, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL led_zext got %h expected %h", got, exp_v); end
    rd(A_LED, 1'b0, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL read_ce_low got %h expected 0", got); end
    @(negedge clk);
    sw_in = 16'h1234;
    sb.push_back(32'd0);
    sb.push_back(32'h0000_1234);
    for (int i = 1; i <= 2; i++) begin
      @(posedge clk); #1;
      rd(A_SW, 1'b1, got); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL sw_edge%0d got %h expected %h", i, got, exp_v); end
    end
  endtask

  task automatic test_oneshot();
    wr(A_LOAD, 32'd5);
    wr(A_CTRL, 32'h5);
    for (int v = 5; v >= 0; v--) sb.push_back(32'(v));
    for (int i = 0; i <= 5; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      rd(A_COUNT, 1'b1, got); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL oneshot_count%0d got %h expected %h", i, got, exp_v); end
    end
    rd(A_STAT, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL oneshot_early_exp got %h expected 0", got); end
    @(posedge clk); #1;
    sb.push_back(32'd1); sb.push_back(32'h4); sb.push_back(32'd0);
    rd(A_STAT, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL oneshot_exp got %h expected %h", got, exp_v); end
    rd(A_CTRL, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL oneshot_ctrl got %h expected %h", got, exp_v); end
    rd(A_COUNT, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL oneshot_count_end got %h expected %h", got, exp_v); end
    checks++;
    if (irq !== 1'b1) begin errors++; $display("FAIL oneshot_irq got %b expected 1", irq); end
    @(posedge clk); #1;
    rd(A_COUNT, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL oneshot_hold got %h expected 0", got); end
    wr(A_STAT, 32'd1);
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL oneshot_irq_clr got %b expected 0", irq); end
  endtask

  task automatic test_auto_reload();
    wr(A_LOAD, 32'd3);
    wr(A_CTRL, 32'h3);
    for (int i = 1; i <= 4; i++) sb.push_back((i == 4) ? 32'd1 : 32'd0);
    for (int i = 1; i <= 4; i++) begin
      @(posedge clk); #1;
      rd(A_STAT, 1'b1, got); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL auto_exp_edge%0d got %h expected %h", i, got, exp_v); end
    end
    rd(A_COUNT, 1'b1, got); checks++;
    if (got !== 32'd3) begin errors++; $display("FAIL auto_reload got %h expected 3", got); end
    wr(A_STAT, 32'd1);
    rd(A_STAT, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL auto_clear got %h expected 0", got); end
    repeat (2) @(posedge clk);
    wr(A_STAT, 32'd1);
    sb.push_back(32'd1); sb.push_back(32'd3);
    rd(A_STAT, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL auto_set_wins got %h expected %h", got, exp_v); end
    rd(A_COUNT, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL auto_period got %h expected %h", got, exp_v); end
    checks++;
    if (irq !== 1'b0) begin errors++; $display("FAIL auto_irq_masked got %b expected 0", irq); end
    wr(A_CTRL, 32'd0);
    wr(A_STAT, 32'd1);
  endtask

  task automatic test_mid_run();
    wr(A_LOAD, 32'd5);
    wr(A_CTRL, 32'h1);
    repeat (3) @(posedge clk);
    wr(A_CTRL, 32'h0);
    sb.push_back(32'd2); sb.push_back(32'd2);
    rd(A_COUNT, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL freeze_count got %h expected %h", got, exp_v); end
    repeat (3) @(posedge clk); #1;
    rd(A_COUNT, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL freeze_hold got %h expected %h", got, exp_v); end
    wr(A_LOAD, 32'd2);
    wr(A_CTRL, 32'h3);
    wr(A_LOAD, 32'd10);
    sb.push_back(32'd1); sb.push_back(32'd0); sb.push_back(32'd10); sb.push_back(32'd9);
    for (int i = 0; i < 4; i++) begin
      if (i > 0) begin @(posedge clk); #1; end
      rd(A_COUNT, 1'b1, got); exp_v = sb.pop_front(); checks++;
      if (got !== exp_v) begin errors++; $display("FAIL newload_step%0d got %h expected %h", i, got, exp_v); end
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    rd(A_COUNT, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL rst_mid_count got %h expected 0", got); end
    rd(A_STAT, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL rst_mid_exp got %h expected 0", got); end
    repeat (2) @(posedge clk); #1;
    rd(A_COUNT, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL rst_mid_idle got %h expected 0", got); end
  endtask

  task automatic test_load_zero();
    wr(A_CTRL, 32'h1);
    rd(A_STAT, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL lz_exp_e0 got %h expected 0", got); end
    @(posedge clk); #1;
    rd(A_STAT, 1'b1, got); checks++;
    if (got !== 32'd1) begin errors++; $display("FAIL lz_exp_e1 got %h expected 1", got); end
    rd(A_CTRL, 1'b1, got); checks++;
    if (got !== 32'd0) begin errors++; $display("FAIL lz_ctrl got %h expected 0", got); end
    wr(A_STAT, 32'd1);
  endtask

  task automatic test_decode();
    logic [31:0] bad[3];
    bad = '{32'h7000_0018, 32'h7000_0102, 32'h7100_0000};
    wr(A_LED, 32'h0000_1111);
    wr(A_LOAD, 32'h0000_0077);
    for (int i = 0; i < 3; i++) wr(bad[i], 32'hFFFF_FFFF);
    wr(A_COUNT, 32'h0000_0055);
    for (int i = 0; i < 3; i++) begin
      rd(bad[i], 1'b1, got); checks++;
      if (got !== 32'd0) begin errors++; $display("FAIL decode_rd%0d got %h expected 0", i, got); end
    end
    sb.push_back(32'h0000_1111); sb.push_back(32'h0000_0077); sb.push_back(32'd0);
    rd(A_LED, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL decode_led got %h expected %h", got, exp_v); end
    rd(A_LOAD, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL decode_load got %h expected %h", got, exp_v); end
    rd(A_COUNT, 1'b1, got); exp_v = sb.pop_front(); checks++;
    if (got !== exp_v) begin errors++; $display("FAIL decode_count got %h expected %h", got, exp_v); end
  endtask

  initial begin
    test_reset();
    test_led_sw();
    test_oneshot();
    test_auto_reload();
    test_mid_run();
    test_load_zero();
    test_decode();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/io_timer_gpio.md
# io_timer_gpio

Memory-mapped I/O device on the I/O side of the memory/IO splitter, serving addresses 0x7000_0000–0x7FFF_FFFF. Holds an LED output register, a synchronised switch input, and a 32-bit down-counting timer with expiry flag and interrupt request. Register reads are combinational so read data is available in the same cycle the splitter presents the access. Writes commit on the clock edge.

## Interface
Parameters:
- `LED_W`, 16, width of LED output register
- `SW_W`, 16, width of switch input

Ports:
- `clk`  in  1  system clock
- `rst`  in  1  synchronous, active-high reset
- `ioCe`  in  1  I/O access enable (`RamEnable` level)
- `ioWe`  in  1  write strobe, valid when `ioCe` is active
- `ioAddr`  in  32  byte address, zeroed by the splitter when not selected
- `ioWtData`  in  32  write data
- `ioRdData`  out  32  combinational read data
- `sw_in`  in  SW_W  asynchronous board switches
- `led_out`  out  LED_W  LED register contents
- `irq`  out  1  timer interrupt request, level

## Operation
- Decode: select when `ioCe` is active, `ioAddr[27:8]==0` and `ioAddr[1:0]==0`, with offset `ioAddr[7:0]`. Any other access is unmapped: reads return 0 and writes are ignored.
- Register map (offsets):
  - 0x00 LED (RW): `led_out = LED[LED_W-1:0]`; read zero-extended.
  - 0x04 SW (RO): synchronised `sw_in`, zero-extended.
  - 0x08 CTRL (RW): bit0 EN, bit1 AUTO (auto-reload), bit2 IE (irq enable); other bits read 0.
  - 0x0C LOAD (RW): 32-bit reload value.
  - 0x10 COUNT (RO): current counter.
  - 0x14 STATUS: bit0 EXP. Write 1 clears it; writing 0 has no effect.
- Writes to RO offsets are ignored. When `ioCe` is inactive, `ioRdData` is 0.
- Switch synchroniser: two flop stages. SW reads the second stage.
- Timer FSM, states IDLE and RUN:
  - IDLE: COUNT holds its value. A CTRL write with EN=1 sets COUNT←LOAD and moves to RUN.
  - RUN, COUNT≠0: COUNT←COUNT−1 each edge.
  - RUN, COUNT==0: EXP←1. If AUTO=1, COUNT←LOAD and stay in RUN. If AUTO=0, EN←0 and go to IDLE with COUNT at 0.
  - RUN, CTRL write with EN=0: go to IDLE and COUNT holds. This takes priority over that edge's decrement or expiry.
  - RUN, CTRL write with EN=1: restart with COUNT←LOAD. No expiry occurs on that edge.
- A LOAD write during RUN does not disturb COUNT. The new value applies at the next reload or restart.
- `irq = EXP & IE`, combinational from registers.
- Arithmetic: COUNT is 32-bit unsigned and never decrements below 0.

## Timing
- Reset values: LED=0, `led_out`=0, CTRL=0, LOAD=0, COUNT=0, EXP=0, state IDLE, synchroniser stages 0, `irq`=0.
- Reset overrides all writes and timer activity on the same edge. Reset mid-count returns the block to IDLE with EXP cleared.
- Write latency:
  - A register written at edge E reads back new data in the cycle after E.
  - `led_out` changes at E.
- Read latency: 0 cycles (combinational on address and register state).
- Expiry period: LOAD+1 cycles from enable to EXP. For example, with LOAD=5 and EN written at edge 0, COUNT reads 5,4,3,2,1,0 after edges 0..5, and EXP=1 after edge 6.
- With AUTO=1, EXP re-asserts every LOAD+1 cycles.
- LOAD=0 with EN=1:
  - AUTO=1: expiry on every edge after enable.
  - AUTO=0: single expiry one edge after enable.
- Simultaneous expiry and STATUS write-1-to-clear: the set wins, so EXP=1.
- SW latency: a `sw_in` change is visible on the SW read after 2 edges.

## Test plan
- Reset: hold `rst`=1 for 2 cycles with random I/O writes → all registers read 0, `led_out`=0, `irq`=0.
- LED/SW:
  - Write 0x0000_A5A5 to 0x7000_0000 → `led_out`=0xA5A5 and read returns 0x0000_A5A5.
  - Set `sw_in`=0x1234 → SW read equals 0x1234 exactly 2 edges later.
- One-shot timer: LOAD=5, CTRL=0x5 → COUNT sequence 5..0, EXP and `irq` high after edge 6, then CTRL reads 0x4 and COUNT stays 0. Write 1 to STATUS → `irq`=0.
- Auto-reload: LOAD=3, CTRL=0x3 → EXP set every 4 cycles. A STATUS clear issued on an expiry edge leaves EXP=1. `irq` stays 0 because IE=0.
- Mid-run control:
  - Write CTRL=0 at COUNT=2 → COUNT frozen at 2.
  - Write LOAD=10 during RUN → current countdown unaffected, next reload uses 10.
  - Assert `rst` mid-count → IDLE with COUNT=0.
- Decode: accesses to 0x7000_0018, 0x7000_0102, and 0x7100_0000, plus a write to COUNT → reads return 0 and no register changes.
